imem_dmem_arbiter: RTL and testbench

- Shares the single core memory port between the instruction fetcher and the load/store unit.
- Arbitrates between the two requesters with data priority and a starvation guard, and allows at most one outstanding transaction.
- Steers data lanes between the XLEN data port and the BUS_WID memory bus.
- Routes each in-order response back to its owner and discards fetch responses killed by a jump.

---
 rtl/imem_dmem_arbiter_pkg.sv | 20 ++
 rtl/imem_dmem_arbiter_lane_steer.sv | 26 ++
 rtl/imem_dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared widths, owner encodings and address helpers for the fetch/data memory arbiter.
package imem_dmem_arbiter_pkg;

   localparam int XLEN      = 32;
   localparam int BUS_WID   = 64;
   localparam int BUS_LEN   = BUS_WID / XLEN;
   localparam int BUS_BYTES = BUS_WID / 8;
   localparam int OFS_W     = $clog2(BUS_BYTES);
   localparam int LANE_W    = (BUS_LEN > 1) ? $clog2(BUS_LEN) : 1;

   // Clears the byte offset within one bus beat.
   localparam logic [XLEN-1:0] BUS_ALIGN = ~XLEN'(BUS_BYTES - 1);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

endpackage

// File: rtl/imem_dmem_arbiter_lane_steer.sv
// Moves XLEN data words onto and off the wide memory bus: write replication,
// byte-enable placement at the addressed word, and read-word extraction.
module arb_lane_steer #(
   parameter  int XLEN    = 32,
   parameter  int BUS_WID = 64,
   localparam int BUS_LEN = BUS_WID / XLEN,
   localparam int LANE_W  = (BUS_LEN > 1) ? $clog2(BUS_LEN) : 1
) (
   input  logic [XLEN-1:0]      wdata,
   input  logic [XLEN/8-1:0]    be,
   input  logic [LANE_W-1:0]    wr_lane,
   input  logic [BUS_WID-1:0]   rdata_bus,
   input  logic [LANE_W-1:0]    rd_lane,
   output logic [BUS_WID-1:0]   wdata_bus,
   output logic [BUS_WID/8-1:0] be_bus,
   output logic [XLEN-1:0]      rdata_word
);

   for (genvar gi = 0; gi < BUS_LEN; gi++) begin : g_lane
      assign wdata_bus[gi*XLEN +: XLEN]     = wdata;
      assign be_bus[gi*(XLEN/8) +: XLEN/8] = (wr_lane == LANE_W'(gi)) ? be : '0;
   end

   assign rdata_word = rdata_bus[rd_lane*XLEN +: XLEN];

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with data
// priority, a fetch starvation guard and a single outstanding transaction.
module imem_dmem_arbiter
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 imem_req,
   input  logic [XLEN-1:0]      imem_addr,
   output logic                 imem_gnt,
   input  logic                 imem_kill,
   output logic [BUS_WID-1:0]   imem_rdata,
   output logic                 imem_resp,
   input  logic                 dmem_req,
   input  logic                 dmem_we,
   input  logic [XLEN-1:0]      dmem_addr,
   input  logic [XLEN-1:0]      dmem_wdata,
   input  logic [XLEN/8-1:0]    dmem_be,
   output logic                 dmem_gnt,
   output logic [XLEN-1:0]      dmem_rdata,
   output logic                 dmem_resp,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_addr,
   output logic [BUS_WID-1:0]   mem_wdata,
   output logic [BUS_BYTES-1:0] mem_be,
   input  logic [BUS_WID-1:0]   mem_rdata,
   input  logic                 mem_resp
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   owner_t            owner_reg, owner_next;
   logic [LANE_W-1:0] lane_reg, lane_next;
   logic              drop_reg, drop_next;
   logic [CNT_W-1:0]  starve_reg, starve_next;

   logic                 can_issue;
   logic                 starved;
   logic [LANE_W-1:0]    req_lane;
   logic [BUS_WID-1:0]   wdata_bus;
   logic [BUS_BYTES-1:0] be_bus;
   logic [XLEN-1:0]      rdata_word;

   arb_lane_steer #(
      .XLEN    (XLEN),
      .BUS_WID (BUS_WID)
   ) u_steer (
      .wdata      (dmem_wdata),
      .be         (dmem_be),
      .wr_lane    (req_lane),
      .rdata_bus  (mem_rdata),
      .rd_lane    (lane_reg),
      .wdata_bus  (wdata_bus),
      .be_bus     (be_bus),
      .rdata_word (rdata_word)
   );

   assign req_lane  = dmem_addr[OFS_W-1:2];
   // Gating with rst keeps the combinational grants quiet while reset is held.
   assign can_issue = rst & ((owner_reg == OWN_IDLE) | mem_resp);
   assign starved   = imem_req & (starve_reg == CNT_W'(STARVE_MAX));
   assign dmem_gnt  = can_issue & dmem_req & ~starved;
   assign imem_gnt  = can_issue & imem_req & ~dmem_gnt;

   assign mem_req   = imem_gnt | dmem_gnt;
   assign mem_we    = dmem_gnt & dmem_we;
   assign mem_addr  = dmem_gnt ? (dmem_addr & BUS_ALIGN) :
                      imem_gnt ? (imem_addr & BUS_ALIGN) : '0;
   assign mem_wdata = dmem_gnt ? wdata_bus : '0;
   assign mem_be    = dmem_gnt ? be_bus : (imem_gnt ? '1 : '0);

   assign imem_resp  = mem_resp & (owner_reg == OWN_INST) & ~drop_reg & ~imem_kill;
   assign imem_rdata = (owner_reg == OWN_INST) ? mem_rdata : '0;
   assign dmem_resp  = mem_resp & (owner_reg == OWN_DATA);
   assign dmem_rdata = (owner_reg == OWN_DATA) ? rdata_word : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_reg  <= OWN_IDLE;
         lane_reg   <= '0;
         drop_reg   <= 1'b0;
         starve_reg <= '0;
      end else begin
         owner_reg  <= owner_next;
         lane_reg   <= lane_next;
         drop_reg   <= drop_next;
         starve_reg <= starve_next;
      end
   end

   always_comb begin
      owner_next  = owner_reg;
      lane_next   = lane_reg;
      drop_next   = drop_reg;
      starve_next = starve_reg;

      if (dmem_gnt) begin
         owner_next = OWN_DATA;
         lane_next  = req_lane;
      end else if (imem_gnt) begin
         owner_next = OWN_INST;
      end else if (mem_resp) begin
         owner_next = OWN_IDLE;
      end

      // A kill coinciding with the fetch response suppresses it directly instead.
      if (owner_reg == OWN_INST) begin
         if (mem_resp)
            drop_next = 1'b0;
         else if (imem_kill)
            drop_next = 1'b1;
      end

      if (dmem_gnt & imem_req) begin
         if (starve_reg != CNT_W'(STARVE_MAX))
            starve_next = starve_reg + 1'b1;
      end else if (imem_gnt | ~imem_req) begin
         starve_next = '0;
      end
   end

   a_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
      !(mem_resp && owner_reg == OWN_IDLE))
      else $warning("mem_resp with no outstanding transaction ignored");

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: fetch, data write/read, contention,
// back-to-back issue, kill handling and asynchronous reset.
module tb_imem_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_kill;
   logic [63:0] imem_rdata;
   logic        imem_resp;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic [63:0] mem_rdata;
   logic        mem_resp;

   int n_tests = 0;
   int n_fail  = 0;
   logic [5:0] exp_d;

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.STARVE_MAX(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_kill  (imem_kill),
      .imem_rdata (imem_rdata),
      .imem_resp  (imem_resp),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_gnt   (dmem_gnt),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b0;
      imem_req = 1'b1; imem_addr = 32'h0000_0104; imem_kill = 1'b0;
      dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_0008;
      dmem_wdata = 32'h1234_5678; dmem_be = 4'hF;
      mem_rdata = 64'h0; mem_resp = 1'b0;
      settle();
      check("rst_ignt", imem_gnt, 1'b0);
      check("rst_dgnt", dmem_gnt, 1'b0);
      check("rst_mreq", mem_req, 1'b0);
      check("rst_maddr", mem_addr, 32'h0);
      check("rst_mbe", mem_be, 8'h0);
      imem_req = 1'b0; dmem_req = 1'b0;
      cyc(); cyc();
      rst = 1'b1;

      // lone fetch, latency 2
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0204;
      settle();
      check("fetch_gnt", imem_gnt, 1'b1);
      check("fetch_addr", mem_addr, 32'h0000_0200);
      check("fetch_be", mem_be, 8'hFF);
      check("fetch_we", mem_we, 1'b0);
      cyc();
      imem_req = 1'b0;
      settle();
      check("fetch_wait_req", mem_req, 1'b0);
      check("fetch_wait_resp", imem_resp, 1'b0);
      cyc();
      mem_resp = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
      settle();
      check("fetch_resp", imem_resp, 1'b1);
      check("fetch_line", imem_rdata, 64'h1122_3344_5566_7788);
      check("fetch_no_dresp", dmem_resp, 1'b0);
      $display("[TB] fetch 0x204 line %h", imem_rdata);
      cyc();
      mem_resp = 1'b0;
      settle();
      check("fetch_resp_end", imem_resp, 1'b0);

      // data write, upper word
      cyc();
      dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_1004;
      dmem_be = 4'h3; dmem_wdata = 32'hAABB_CCDD;
      settle();
      check("wr_gnt", dmem_gnt, 1'b1);
      check("wr_we", mem_we, 1'b1);
      check("wr_addr", mem_addr, 32'h0000_1000);
      check("wr_be", mem_be, 8'h30);
      check("wr_wdata", mem_wdata, 64'hAABB_CCDD_AABB_CCDD);
      cyc();
      dmem_req = 1'b0; mem_resp = 1'b1;
      settle();
      check("wr_resp", dmem_resp, 1'b1);
      check("wr_no_iresp", imem_resp, 1'b0);
      $display("[TB] write 0x1004 be %h", 4'h3);
      cyc();
      mem_resp = 1'b0;

      // data read upper word, then back-to-back read of lower word
      cyc();
      dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_1004; dmem_be = 4'hF;
      settle();
      check("rd_gnt", dmem_gnt, 1'b1);
      check("rd_we", mem_we, 1'b0);
      check("rd_be", mem_be, 8'hF0);
      cyc();
      mem_resp = 1'b1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
      dmem_addr = 32'h0000_2000;
      settle();
      check("rd_resp", dmem_resp, 1'b1);
      check("rd_word_hi", dmem_rdata, 32'hDEAD_BEEF);
      check("b2b_gnt", dmem_gnt, 1'b1);
      check("b2b_addr", mem_addr, 32'h0000_2000);
      check("b2b_be", mem_be, 8'h0F);
      $display("[TB] read 0x1004 data %h", dmem_rdata);
      cyc();
      dmem_req = 1'b0; mem_rdata = 64'hCAFE_F00D_1234_5678;
      settle();
      check("b2b_resp", dmem_resp, 1'b1);
      check("rd_word_lo", dmem_rdata, 32'h1234_5678);
      $display("[TB] read 0x2000 data %h", dmem_rdata);
      cyc();
      mem_resp = 1'b0;

      // contention: both requesters held, memory answers every cycle
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0400;
      dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h0000_3004;
      exp_d = 6'b011011;
      for (int k = 0; k < 6; k++) begin
         settle();
         check("cont_dgnt", dmem_gnt, exp_d[k]);
         check("cont_ignt", imem_gnt, !exp_d[k]);
         check("cont_one", imem_gnt & dmem_gnt, 1'b0);
         if (k > 0) begin
            check("cont_dresp", dmem_resp, exp_d[k-1]);
            check("cont_iresp", imem_resp, !exp_d[k-1]);
         end
         $display("[TB] contention grant %0d -> %s", k, dmem_gnt ? "D" : "I");
         cyc();
         mem_resp = 1'b1;
      end
      imem_req = 1'b0; dmem_req = 1'b0;
      settle();
      check("cont_last_iresp", imem_resp, 1'b1);
      check("cont_idle_req", mem_req, 1'b0);
      cyc();
      mem_resp = 1'b0;

      // kill one cycle after grant, latency 3
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0300;
      settle();
      check("kill_gnt", imem_gnt, 1'b1);
      cyc();
      imem_req = 1'b0; imem_kill = 1'b1;
      cyc();
      imem_kill = 1'b0;
      cyc();
      mem_resp = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      settle();
      check("kill_dropped", imem_resp, 1'b0);
      $display("[TB] fetch 0x300 killed");
      cyc();
      // a kill in the grant cycle leaves that new fetch alone
      mem_resp = 1'b0; imem_req = 1'b1; imem_kill = 1'b1; imem_addr = 32'h0000_0340;
      settle();
      check("kill_new_gnt", imem_gnt, 1'b1);
      check("kill_new_addr", mem_addr, 32'h0000_0340);
      cyc();
      imem_req = 1'b0; imem_kill = 1'b0;
      cyc();
      mem_resp = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
      settle();
      check("kill_new_resp", imem_resp, 1'b1);
      check("kill_new_line", imem_rdata, 64'h5555_6666_7777_8888);
      $display("[TB] fetch 0x340 line %h", imem_rdata);
      cyc();
      mem_resp = 1'b0;

      // kill coinciding with the response suppresses it; next fetch is clean
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0380;
      cyc();
      imem_req = 1'b0; imem_kill = 1'b1; mem_resp = 1'b1;
      settle();
      check("kill_same_resp", imem_resp, 1'b0);
      cyc();
      imem_kill = 1'b0; mem_resp = 1'b0; imem_req = 1'b1; imem_addr = 32'h0000_03C0;
      cyc();
      imem_req = 1'b0; mem_resp = 1'b1;
      settle();
      check("kill_after_resp", imem_resp, 1'b1);
      $display("[TB] fetch 0x3c0 after same-cycle kill");
      cyc();
      mem_resp = 1'b0;

      // asynchronous reset mid-fetch
      cyc();
      imem_req = 1'b1; imem_addr = 32'h0000_0500;
      settle();
      check("rstm_gnt", imem_gnt, 1'b1);
      cyc();
      dmem_req = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
      settle();
      check("rstm_busy", dmem_gnt, 1'b0);
      rst = 1'b0;
      #1;
      check("rstm_ignt", imem_gnt, 1'b0);
      check("rstm_dgnt", dmem_gnt, 1'b0);
      check("rstm_mreq", mem_req, 1'b0);
      check("rstm_maddr", mem_addr, 32'h0);
      check("rstm_irdata", imem_rdata, 64'h0);
      imem_req = 1'b0; dmem_req = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      mem_resp = 1'b1;
      settle();
      check("stale_iresp", imem_resp, 1'b0);
      check("stale_dresp", dmem_resp, 1'b0);
      check("stale_irdata", imem_rdata, 64'h0);
      $display("[TB] reset mid-fetch, stale response ignored");
      cyc();
      mem_resp = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
